ex_mdu: RTL and testbench
=========================

# ex_mdu

Execute-stage multiply/divide unit for the RV32M extension. It sits directly downstream of the ID/EX pipeline register and consumes its registered instruction, operands and destination address. MUL* and DIV*/REM* are executed with a radix-2 iterative datapath. While an operation is in flight the unit requests a pipeline hold, so the ID/EX register keeps presenting the same instruction. The result is then handed to the register-file write port.

## Interface
Parameters:
- none (widths fixed by `defines.v`: 32-bit data, 5-bit register address)

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  synchronous reset, active-high.
- `inst_i`  in  32  instruction from ID/EX.
- `reg1_rdata_i`  in  32  rs1 value (dividend / multiplicand).
- `reg2_rdata_i`  in  32  rs2 value (divisor / multiplier).
- `reg_waddr_i`  in  5  rd from ID/EX.
- `flush_i`  in  1  jump/interrupt flush; aborts any operation.
- `stall_i`  in  1  hold applied to ID/EX by another requester; keeps DONE from retiring.
- `hold_req_o`  out  1  hold request to the pipeline controller (maps to `Hold_Id`).
- `busy_o`  out  1  state is not IDLE.
- `reg_we_o`  out  1  register-file write enable.
- `reg_waddr_o`  out  5  register-file write address.
- `result_o`  out  32  register-file write data.

## Operation
- **MDU op:** opcode `0110011` with funct7 `0000001`; funct3 selects MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. Any other instruction, including `INST_NOP`, is not an MDU op.
  - The unit ignores non-MDU instructions: `reg_we_o`=0, `hold_req_o`=0, `result_o`=0.
- **Start:** state IDLE, MDU op decoded, `flush_i`=0.
  - Capture operand magnitudes, sign flags, funct3 and `reg_waddr_i`.
  - Load the counter with 31 and go to BUSY.
  - Signed ops (DIV, REM, MULH, MULHSU) take the two's-complement magnitude of negative operands. MULHSU treats rs2 as unsigned.
- **Divide special cases** resolve in the start cycle, with no hold and no state change:
  - `reg_we_o`=1, `reg_waddr_o`=`reg_waddr_i`.
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- **BUSY:** one iteration per cycle; the counter decrements and leaves BUSY after the iteration with count 0.
  - Divide: restoring shift-subtract, 33-bit partial remainder.
  - Multiply: shift-add into a 64-bit accumulator.
- **Leaving BUSY:** apply the sign fix and register `result_o`.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Product is negated if the signs differ.
  - MUL returns the low word; MULH* return the high word.
  - Next state is DONE.
- **DONE:** `reg_we_o`=1, `reg_waddr_o` = the captured rd, `hold_req_o`=0.
  - Return to IDLE when `stall_i`=0; otherwise stay in DONE with outputs stable.
  - Repeated writes of the same value are benign.
- **rd = x0:** executed normally; the register file discards the write.
- **Flush:** `flush_i`=1 in any state forces IDLE on the next edge. It suppresses `reg_we_o` and `hold_req_o` in the same cycle and drops any partial result.
- **Reset mid-operation:** same as flush. The next instruction presented starts cleanly.

## Timing
- **Reset values:** state IDLE, `hold_req_o`=0, `busy_o`=0, `reg_we_o`=0, `reg_waddr_o`=0, `result_o`=0, counter=0.
- **Iterative op**, with T0 = start cycle:
  - `hold_req_o`=1 from T0 through T32 (combinational in T0, state-driven after).
  - BUSY for T1..T32.
  - DONE at T33 with `reg_we_o`=1.
  - ID/EX advances at the end of T33, giving a total EX occupancy of 34 cycles.
- **`busy_o`:** high T1..T33.
- **Special-case divide:** one cycle, no hold.
- **Back-to-back MDU ops:** the second starts in the cycle after DONE retires (IDLE). There are no bubbles beyond that.
- **`hold_req_o`:** combinational from state, decode and `flush_i`. There is no combinational path from `stall_i` to `hold_req_o`.

## Configuration
- **`MDU_FAST_MUL_EN` defined:**
  - All four MUL variants complete in the start cycle via a combinational 33×33 signed multiplier: `reg_we_o`=1, no hold, state stays IDLE.
  - Divides are unchanged.
- **`MDU_FAST_MUL_EN` undefined:** multiplies use the iterative 34-cycle path described above.

## Test plan
- **DIV:** rs1=-7 (0xFFFFFFF9), rs2=2, rd=5 → `hold_req_o` high 33 cycles, then at T33 `reg_we_o`=1, `reg_waddr_o`=5, `result_o`=0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF.
- **Divide special cases:**
  - DIVU 100/0 → same cycle, no hold, `result_o`=0xFFFFFFFF.
  - REMU 100/0 → 100.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- **Multiply:** MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH → 0x00000000; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF; MUL 3×-4 → 0xFFFFFFF4.
  - Run once with the macro defined (1 cycle each, no hold) and once without (34 cycles each).
- **Flush:** `flush_i` pulsed at T10 of a DIV → `hold_req_o`=0 in T10, IDLE at T11, `reg_we_o` never asserts. A following DIVU 9/3 returns 3.
- **Stall:** `stall_i`=1 during T33–T35 → state stays DONE with `reg_we_o`=1 and `result_o` stable; returns to IDLE after `stall_i` drops.
- **Non-MDU and reset:** an ADD (funct7 0) or `INST_NOP` → no hold, `reg_we_o`=0. `rst` asserted at T5 → all outputs at reset values at T6.

Source files
------------

// File: rtl/ex_mdu.sv
// ex_mdu -- RV32M execute-stage multiply/divide unit.
//
// Consumes the instruction, operands and rd held in the ID/EX register.
// MUL/MULH/MULHSU/MULHU and DIV/DIVU/REM/REMU are executed with a radix-2
// iterative datapath (one bit per cycle, 32 iterations). While an iterative
// operation is in flight hold_req_o keeps ID/EX presenting the same
// instruction. The result is written to the register file in the DONE state.
// Divide-by-zero and signed overflow resolve in the start cycle.
//
// Optional feature: define MDU_FAST_MUL_EN to complete all multiplies in the
// start cycle with a combinational 33x33 signed multiplier.
//
// Ports:
//   clk           core clock
//   rst           synchronous reset, active-high
//   inst_i        instruction from ID/EX
//   reg1_rdata_i  rs1 value (dividend / multiplicand)
//   reg2_rdata_i  rs2 value (divisor / multiplier)
//   reg_waddr_i   rd from ID/EX
//   flush_i       jump/interrupt flush, aborts any operation
//   stall_i       external hold on ID/EX, keeps DONE from retiring
//   hold_req_o    hold request to the pipeline controller
//   busy_o        unit is not idle
//   reg_we_o      register-file write enable
//   reg_waddr_o   register-file write address
//   result_o      register-file write data
module ex_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] reg1_rdata_i,
  input  logic [31:0] reg2_rdata_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        flush_i,
  input  logic        stall_i,
  output logic        hold_req_o,
  output logic        busy_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] result_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        neg1_q;
  logic        neg2_q;
  logic [31:0] op_q;      // multiplicand (mul) or divisor (div) magnitude
  logic [63:0] wrk_q;     // mul: {acc_hi, multiplier/acc_lo}; div: [31:0] dividend/quotient
  logic [31:0] rem_q;     // div: partial remainder
  logic [31:0] result_q;

  // ---------------------------------------------------------------- decode
  logic [2:0]  f3;
  logic        is_mdu;
  logic        is_div;
  logic        rs1_signed;
  logic        rs2_signed;
  logic        neg1;
  logic        neg2;
  logic [31:0] mag1;
  logic [31:0] mag2;

  assign f3         = inst_i[14:12];
  assign is_mdu     = (inst_i[6:0] == OPC_OP) && (inst_i[31:25] == F7_MULDIV);
  assign is_div     = f3[2];
  assign rs1_signed = (f3 == F3_DIV) || (f3 == F3_REM) || (f3 == F3_MULH) || (f3 == F3_MULHSU);
  assign rs2_signed = (f3 == F3_DIV) || (f3 == F3_REM) || (f3 == F3_MULH);
  assign neg1       = rs1_signed & reg1_rdata_i[31];
  assign neg2       = rs2_signed & reg2_rdata_i[31];
  assign mag1       = neg1 ? -reg1_rdata_i : reg1_rdata_i;
  assign mag2       = neg2 ? -reg2_rdata_i : reg2_rdata_i;

  // ------------------------------------------------- single-cycle results
  logic        div_zero;
  logic        div_ovf;
  logic        one_shot;
  logic [31:0] one_shot_res;
  logic [31:0] special_res;

  assign div_zero = is_div && (reg2_rdata_i == 32'd0);
  // Only the signed forms (DIV/REM have funct3[0]=0) can overflow.
  assign div_ovf  = is_div && !f3[0] && (reg1_rdata_i == 32'h8000_0000) &&
                    (reg2_rdata_i == 32'hFFFF_FFFF);

  // funct3[1] distinguishes REM* from DIV*.
  assign special_res = f3[1] ? (div_zero ? reg1_rdata_i : 32'd0)
                             : (div_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

`ifdef MDU_FAST_MUL_EN
  logic signed [65:0] fast_prod;
  logic        [1:0]  fast_unused;

  // The extra top bit carries each operand's signedness, so one signed
  // multiplier covers MUL, MULH, MULHSU and MULHU.
  assign fast_prod    = $signed({neg1 & reg1_rdata_i[31] | (rs1_signed & reg1_rdata_i[31]), reg1_rdata_i}) *
                        $signed({rs2_signed & reg2_rdata_i[31], reg2_rdata_i});
  assign fast_unused  = fast_prod[65:64];
  assign one_shot     = div_zero || div_ovf || !is_div;
  assign one_shot_res = is_div ? special_res
                      : (f3 == F3_MUL) ? fast_prod[31:0] : fast_prod[63:32];
`else
  assign one_shot     = div_zero || div_ovf;
  assign one_shot_res = special_res;
`endif

  // ------------------------------------------------------------ handshake
  logic start;
  logic one_shot_we;

  assign start       = (state_q == S_IDLE) && is_mdu && !flush_i && !one_shot;
  assign one_shot_we = (state_q == S_IDLE) && is_mdu && !flush_i && one_shot;

  // stall_i only influences the DONE->IDLE transition, so it never reaches
  // hold_req_o combinationally.
  assign hold_req_o = !flush_i && (start || (state_q == S_BUSY));
  assign busy_o     = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    reg_we_o    = 1'b0;
    reg_waddr_o = 5'd0;
    result_o    = 32'd0;
    if (!flush_i) begin
      if (state_q == S_DONE) begin
        reg_we_o    = 1'b1;
        reg_waddr_o = rd_q;
        result_o    = result_q;
      end else if (one_shot_we) begin
        reg_we_o    = 1'b1;
        reg_waddr_o = reg_waddr_i;
        result_o    = one_shot_res;
      end
    end
  end

  // ------------------------------------------------------- iteration step
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic        div_fit;
  logic [31:0] rem_nxt;
  logic [63:0] div_nxt;
  logic [63:0] wrk_nxt;

  // Shift-add: add the multiplicand into the high half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign mul_sum = {1'b0, wrk_q[63:32]} + (wrk_q[0] ? {1'b0, op_q} : 33'd0);
  assign mul_nxt = {mul_sum, wrk_q[31:1]};

  // Restoring divide: 33-bit partial remainder = remainder shifted left with
  // the next dividend bit; subtract the divisor and keep it if no borrow.
  assign div_shift = {rem_q, wrk_q[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, op_q};
  assign div_fit   = !div_diff[33];
  // The kept remainder is always below the divisor, so 32 bits suffice.
  assign rem_nxt   = div_fit ? div_diff[31:0] : div_shift[31:0];
  assign div_nxt   = {32'd0, wrk_q[30:0], div_fit};

  assign wrk_nxt = f3_q[2] ? div_nxt : mul_nxt;

  // ------------------------------------------------------------ sign fix
  logic        sgn_diff;
  logic [63:0] prod_fix;
  logic [31:0] result_d;

  assign sgn_diff = neg1_q ^ neg2_q;
  assign prod_fix = sgn_diff ? -wrk_nxt : wrk_nxt;

  always_comb begin
    result_d = 32'd0;
    if (f3_q[2]) begin
      if (f3_q[1]) result_d = neg1_q   ? -rem_nxt       : rem_nxt;
      else         result_d = sgn_diff ? -wrk_nxt[31:0] : wrk_nxt[31:0];
    end else begin
      result_d = (f3_q == F3_MUL) ? prod_fix[31:0] : prod_fix[63:32];
    end
  end

  // ------------------------------------------------------------ state
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      f3_q     <= 3'd0;
      rd_q     <= 5'd0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      op_q     <= 32'd0;
      wrk_q    <= 64'd0;
      rem_q    <= 32'd0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_BUSY;
            cnt_q   <= 5'd31;
            f3_q    <= f3;
            rd_q    <= reg_waddr_i;
            neg1_q  <= neg1;
            neg2_q  <= neg2;
            rem_q   <= 32'd0;
            if (is_div) begin
              op_q  <= mag2;
              wrk_q <= {32'd0, mag1};
            end else begin
              op_q  <= mag1;
              wrk_q <= {32'd0, mag2};
            end
          end
        end
        S_BUSY: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else begin
            wrk_q <= wrk_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
              state_q  <= S_DONE;
              result_q <= result_d;
            end
          end
        end
        S_DONE: begin
          if (flush_i || !stall_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Instruction fields that do not affect this unit.
  logic sig_unused;
  assign sig_unused = ^{inst_i[24:15], div_diff[32]};

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu -- self-checking bench for ex_mdu.
//
// A driver plays the role of the ID/EX register: it presents an instruction,
// holds it while the unit is expected to request a hold, and advances once
// the result is expected to retire. For each cycle it sets the outputs the
// unit must show, derived from an arithmetic model of RV32M and the cycle
// timeline of the unit; a single negedge process compares them.
// Build with +define+MDU_FAST_MUL_EN for the fast-multiply variant.
module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] reg1_rdata_i;
  logic [31:0] reg2_rdata_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic        stall_i;
  logic        hold_req_o;
  logic        busy_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] result_o;

  ex_mdu dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .reg1_rdata_i (reg1_rdata_i),
    .reg2_rdata_i (reg2_rdata_i),
    .reg_waddr_i  (reg_waddr_i),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .hold_req_o   (hold_req_o),
    .busy_o       (busy_o),
    .reg_we_o     (reg_we_o),
    .reg_waddr_o  (reg_waddr_o),
    .result_o     (result_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  int total = 0;
  int bad   = 0;

  // Expected outputs for the current cycle.
  bit          chk_en     = 1'b0;
  bit          chk_waddr  = 1'b0;
  bit          chk_result = 1'b0;
  logic        exp_hold;
  logic        exp_busy;
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_result;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("hold_req", {31'd0, hold_req_o}, {31'd0, exp_hold});
      check("busy",     {31'd0, busy_o},     {31'd0, exp_busy});
      check("reg_we",   {31'd0, reg_we_o},   {31'd0, exp_we});
      if (chk_waddr)  check("reg_waddr", {27'd0, reg_waddr_o}, {27'd0, exp_waddr});
      if (chk_result) check("result",    result_o, exp_result);
    end
  end

  // RV32M reference semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      ua = longint'({32'd0, a});
    longint      ub = longint'({32'd0, b});
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf)    return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf)    return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle_zero();
    exp_hold = 1'b0; exp_busy = 1'b0; exp_we = 1'b0;
    exp_waddr = 5'd0; exp_result = 32'd0;
    chk_waddr = 1'b1; chk_result = 1'b1;
  endtask

  // Present one MDU instruction and follow it to retirement (or flush).
  // lit is the hand-computed result, which also pins the model.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] lit,
                        input int stall_from, input int stall_len, input int flush_at);
    logic [31:0] m;
    bit          one_shot;
    m = model(f3, a, b);
    check("model", m, lit);
    one_shot = f3[2] && ((b == 32'd0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`ifdef MDU_FAST_MUL_EN
    one_shot = one_shot || !f3[2];
`endif
    for (int k = 0; k < 60; k++) begin
      step();
      inst_i       = enc(7'b0000001, f3, rd);
      reg1_rdata_i = a;
      reg2_rdata_i = b;
      reg_waddr_i  = rd;
      stall_i      = (k >= stall_from) && (k < stall_from + stall_len);
      flush_i      = (k == flush_at);
      if (one_shot) begin
        exp_hold = 1'b0; exp_busy = 1'b0; exp_we = 1'b1;
        exp_waddr = rd; exp_result = m;
        chk_waddr = 1'b1; chk_result = 1'b1;
        return;
      end
      if (k <= 32) begin
        exp_hold = !flush_i; exp_busy = (k >= 1); exp_we = 1'b0;
        chk_waddr = 1'b0; chk_result = 1'b0;
      end else begin
        exp_hold = 1'b0; exp_busy = 1'b1; exp_we = !flush_i;
        exp_waddr = rd; exp_result = m;
        chk_waddr = !flush_i; chk_result = !flush_i;
      end
      if (flush_i) begin
        // Pipeline is flushed: a bubble follows and the unit must be idle.
        step();
        inst_i = INST_NOP; flush_i = 1'b0; stall_i = 1'b0;
        exp_hold = 1'b0; exp_busy = 1'b0; exp_we = 1'b0;
        chk_waddr = 1'b0; chk_result = 1'b1; exp_result = 32'd0;
        return;
      end
      if (k >= 33 && !stall_i) return;
    end
    check("retire_timeout", 32'd1, 32'd0);
  endtask

  task automatic present_other(input logic [31:0] inst);
    step();
    inst_i = inst; reg1_rdata_i = 32'd5; reg2_rdata_i = 32'd6; reg_waddr_i = 5'd3;
    flush_i = 1'b0; stall_i = 1'b0;
    exp_hold = 1'b0; exp_busy = 1'b0; exp_we = 1'b0; exp_result = 32'd0;
    chk_waddr = 1'b0; chk_result = 1'b1;
  endtask

  initial begin
    rst = 1'b1; inst_i = INST_NOP; reg1_rdata_i = 32'd0; reg2_rdata_i = 32'd0;
    reg_waddr_i = 5'd0; flush_i = 1'b0; stall_i = 1'b0;
    step();
    step();
    expect_idle_zero();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    expect_idle_zero();

    // Iterative divide and remainder.
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, -1, 0, -1);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, -1, 0, -1);
    // Divide special cases.
    run_op(3'd5, 32'd100, 32'd0, 5'd7, 32'hFFFF_FFFF, -1, 0, -1);
    run_op(3'd7, 32'd100, 32'd0, 5'd8, 32'd100, -1, 0, -1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, -1, 0, -1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, -1, 0, -1);
    // Multiplies.
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, -1, 0, -1);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'd0, -1, 0, -1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd13, 32'hFFFF_FFFF, -1, 0, -1);
    run_op(3'd0, 32'd3, 32'hFFFF_FFFC, 5'd14, 32'hFFFF_FFF4, -1, 0, -1);
    run_op(3'd0, 32'd6, 32'd7, 5'd0, 32'd42, -1, 0, -1);
    run_op(3'd1, 32'h1234_5678, 32'h8765_4321, 5'd15, 32'hF76C_768D, -1, 0, -1);
    // Flush at T10, then a clean divide.
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, -1, 0, 10);
    run_op(3'd5, 32'd9, 32'd3, 5'd16, 32'd3, -1, 0, -1);
    // Stall held through T33..T35.
    run_op(3'd5, 32'd100, 32'd7, 5'd17, 32'd14, 33, 3, -1);
    run_op(3'd7, 32'd100, 32'd7, 5'd18, 32'd2, -1, 0, -1);
    // Non-MDU instructions.
    present_other({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011});
    present_other(INST_NOP);

    // Reset asserted at T5 of a divide.
    for (int k = 0; k <= 5; k++) begin
      step();
      inst_i = enc(7'b0000001, 3'd4, 5'd20); reg1_rdata_i = 32'd100;
      reg2_rdata_i = 32'd7; reg_waddr_i = 5'd20; flush_i = 1'b0; stall_i = 1'b0;
      rst = (k == 5);
      exp_hold = 1'b1; exp_busy = (k >= 1); exp_we = 1'b0;
      chk_waddr = 1'b0; chk_result = 1'b0;
    end
    step();
    rst = 1'b0; inst_i = INST_NOP;
    expect_idle_zero();
    run_op(3'd5, 32'd9, 32'd3, 5'd21, 32'd3, -1, 0, -1);

    step();
    chk_en = 1'b0;
    inst_i = INST_NOP;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
